// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and default widths for the iterative divider
package div_pkg;
    localparam int DEF_W = 32;
    localparam int DEF_P = 64;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract step producing a single quotient bit
module div_step import div_pkg::*; #(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] r,
    input  logic         msb,
    input  logic [W-1:0] d,
    output logic [W-1:0] r_next,
    output logic         qbit
);
    logic [W:0] rs;
    logic [W:0] diff;
    assign rs     = {r, msb};
    assign diff   = rs - {1'b0, d};
    assign qbit   = ~diff[W];
    assign r_next = qbit ? diff[W-1:0] : rs[W-1:0];
endmodule

// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring divider with fixed-point fraction bits and valid/ready handshake
module iter_divider import div_pkg::*; #(
    parameter int ARG_BIT_WIDTH = DEF_W,
    parameter int PRECISION     = DEF_P
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ARG_BIT_WIDTH-1:0]             a,
    input  logic [ARG_BIT_WIDTH-1:0]             b,
    input  logic                                 is_signed,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ARG_BIT_WIDTH+PRECISION-1:0]   quotient,
    output logic [ARG_BIT_WIDTH-1:0]             remainder,
    output logic                                 dz,
    output logic                                 ovf
);
    localparam int W  = ARG_BIT_WIDTH;
    localparam int P  = PRECISION;
    localparam int WP = W + P;
    localparam int CW = $clog2(WP + 1);
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [WP-1:0] q;
    logic [W-1:0]  r;
    logic [W-1:0]  d;
    logic          sgn;
    logic          sa;
    logic          sb;
    logic          a_neg;
    logic          b_neg;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W-1:0]  r_nx;
    logic          qb;
    assign a_neg     = is_signed & a[W-1];
    assign b_neg     = is_signed & b[W-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign quotient  = q;
    assign remainder = r;
    div_step #(.W(W)) u_step (
        .r      (r),
        .msb    (q[WP-1]),
        .d      (d),
        .r_next (r_nx),
        .qbit   (qb)
    );
    // q doubles as the dividend shifter: dividend bits leave at the top, quotient bits enter at the bottom
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            d     <= '0;
            sgn   <= 1'b0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sgn <= is_signed;
                    sa  <= a_neg;
                    sb  <= b_neg;
                    cnt <= '0;
                    ovf <= 1'b0;
                    r   <= '0;
                    if (b == '0) begin
                        state <= DONE;
                        dz    <= 1'b1;
                        q     <= '0;
                    end else begin
                        state <= CALC;
                        q     <= WP'(a_mag) << P;
                        d     <= b_mag;
                    end
                end
                CALC: begin
                    q   <= {q[WP-2:0], qb};
                    r   <= r_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WP - 1)) state <= FIX;
                end
                FIX: begin
                    q     <= (sa ^ sb) ? -q : q;
                    r     <= sa ? -r : r;
                    // a negated magnitude always fits; only a positive result can reach 2^(WP-1)
                    ovf   <= sgn & ~(sa ^ sb) & q[WP-1];
                    state <= DONE;
                end
                default: if (out_ready) begin
                    state <= IDLE;
                    dz    <= 1'b0;
                    ovf   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed scoreboard bench for iter_divider at W=32, P=64
module tb_iter_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [95:0] quotient;
    logic [31:0] remainder;
    logic        dz;
    logic        ovf;
    int errors = 0;
    int checks = 0;
    typedef struct {
        logic [95:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
    } exp_t;
    exp_t sb[$];
    always #5 clk = ~clk;
    iter_divider #(.ARG_BIT_WIDTH(32), .PRECISION(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .ovf       (ovf)
    );
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic s);
        exp_t e;
        logic na, nb;
        logic [31:0] ma, mb;
        logic [127:0] am, bm, qq, rr;
        na = s & av[31];
        nb = s & bv[31];
        ma = na ? -av : av;
        mb = nb ? -bv : bv;
        e.dz = (bv == 32'd0);
        e.ovf = s && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF;
        if (e.dz) begin
            e.q = '0;
            e.r = '0;
        end else begin
            am = {96'd0, ma} << 64;
            bm = {96'd0, mb};
            qq = am / bm;
            rr = am % bm;
            e.q = (na ^ nb) ? -qq[95:0] : qq[95:0];
            e.r = na ? -rr[31:0] : rr[31:0];
        end
        return e;
    endfunction
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic s);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_ready", 128'(in_ready), 128'(1));
        a = av;
        b = bv;
        is_signed = s;
        in_valid = 1'b1;
        sb.push_back(model(av, bv, s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask
    task automatic collect(input int lat);
        int n = 1;
        exp_t e;
        while (!out_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("out_valid", 128'(out_valid), 128'(1));
        if (lat > 0) chk("latency", 128'(n), 128'(lat));
        e = sb.pop_front();
        chk("quotient", 128'(quotient), 128'(e.q));
        chk("remainder", 128'(remainder), 128'(e.r));
        chk("dz", 128'(dz), 128'(e.dz));
        chk("ovf", 128'(ovf), 128'(e.ovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_ready", 128'(in_ready), 128'(1));
        chk("idle_flags", 128'({dz, ovf, out_valid}), 128'(0));
    endtask
    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_quotient", 128'(quotient), 128'(0));
        chk("rst_remainder", 128'(remainder), 128'(0));
        chk("rst_flags", 128'({dz, ovf}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        send(32'd7, 32'd2, 1'b0);           collect(98);
        send(32'd1, 32'd3, 1'b0);           collect(98);
        send(32'd5, 32'd0, 1'b0);           collect(1);
        send(-32'sd7, 32'd2, 1'b1);         collect(98);
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); collect(98);
        send(32'd100, -32'sd7, 1'b1);       collect(0);
        send(-32'sd100, -32'sd7, 1'b1);     collect(0);
        send(32'hFFFF_FFFF, 32'd1, 1'b0);   collect(0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); collect(0);
        send(32'h8000_0000, 32'd0, 1'b1);   collect(1);
        for (int i = 0; i < 6; i++) begin
            send($urandom, $urandom_range(1, 32'hFFFF), 1'(i % 2));
            collect(0);
        end
        // hold the result with out_ready low while a stray request is offered
        send(32'd22, 32'd7, 1'b0);
        for (int n = 0; n < 300 && !out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        e = sb[0];
        a = 32'd9;
        b = 32'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 128'(out_valid), 128'(1));
            chk("hold_ready", 128'(in_ready), 128'(0));
            chk("hold_quotient", 128'(quotient), 128'(e.q));
            chk("hold_remainder", 128'(remainder), 128'(e.r));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("release_idle", 128'(in_ready), 128'(1));
        chk("release_valid", 128'(out_valid), 128'(0));
        void'(sb.pop_front());
        // reset in the middle of the iteration phase
        send(32'd7, 32'd2, 1'b0);
        repeat (39) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 128'(out_valid), 128'(0));
        chk("midrst_quotient", 128'(quotient), 128'(0));
        chk("midrst_remainder", 128'(remainder), 128'(0));
        chk("midrst_flags", 128'({dz, ovf}), 128'(0));
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", 128'(in_ready), 128'(1));
        send(32'd1, 32'd3, 1'b0);
        collect(98);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter ARG_BIT_WIDTH, default 32, meaning operand width W (W >= 2).
REQ-002 SHALL have parameter PRECISION, default 64, meaning fraction bits P in the quotient (P >= 0).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands and mode present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port a  input  W  dividend.
REQ-008 SHALL have port b  input  W  divisor.
REQ-009 SHALL have port is_signed  input  1  1 = two's-complement operands and results; 0 = unsigned.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port quotient  output  W+P  [W+P-1:P] integer part, [P-1:0] fraction part.
REQ-013 SHALL have port remainder  output  W  final partial remainder.
REQ-014 SHALL have port dz  output  1  divide-by-zero for the current result.
REQ-015 SHALL have port ovf  output  1  signed overflow for the current result.

Function
REQ-016 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-017 SHALL accept on an edge with in_valid && in_ready, capturing a, b, is_signed; other edges ignore inputs.
REQ-018 SHALL, when accepting with b == 0, go IDLE -> DONE directly: dz = 1, quotient = 0, remainder = 0, ovf = 0; out_valid after exactly 1 edge.
REQ-019 SHALL otherwise go to CALC, holding |a| left-extended by P zero bits and |b| (magnitudes taken only if is_signed).
REQ-020 SHALL in CALC produce one quotient bit per edge, MSB first, by restoring shift-subtract; exactly W+P CALC edges.
REQ-021 SHALL satisfy |a|*2^P = |q|*|b| + |r|, 0 <= |r| < |b|, where q, r are the unsigned magnitudes at end of CALC.
REQ-022 SHALL in FIX (one edge) negate q if is_signed and sign(a) != sign(b), and negate r if is_signed and a < 0 (truncation toward zero).
REQ-023 SHALL set ovf = 1 in FIX iff is_signed and the signed quotient does not fit in W+P two's-complement bits (only a = -2^(W-1), b = -1); quotient then holds the wrapped value.
REQ-024 SHALL give latency W+P+2 edges from accepting edge to out_valid = 1 for b != 0.
REQ-025 SHALL in DONE hold out_valid, quotient, remainder, dz, ovf stable until an edge with out_ready = 1, then go to IDLE; in_ready = 1 on the following cycle.
REQ-026 SHALL not accept a new request while in CALC, FIX or DONE (no back-to-back overlap).
REQ-027 SHALL keep dz and ovf meaningful only while out_valid = 1; they SHALL be 0 in IDLE.

Reset
REQ-028 SHALL on rst_n = 0, immediately and regardless of state, enter IDLE, discard any operation in flight: out_valid = 0, quotient = 0, remainder = 0, dz = 0, ovf = 0, iteration counter = 0.
REQ-029 SHALL have in_ready = 1 on the first cycle after rst_n deasserts.

Structure
REQ-030 SHALL place the FSM state enum and default width constants in shared package div_pkg.
REQ-031 SHALL isolate one restoring step (shift, compare, subtract, quotient bit) in sub-module div_step, instantiated once.
REQ-032 SHALL size the iteration counter as clog2(W+P+1) bits.

Verification (W=32, P=64)
REQ-033 SHALL test a=7, b=2, unsigned -> quotient integer 3, fraction 0x8000_0000_0000_0000, remainder 0, out_valid 98 edges after accept.
REQ-034 SHALL test a=1, b=3, unsigned -> integer 0, fraction 0x5555_5555_5555_5555, remainder 1, dz=0.
REQ-035 SHALL test b=0 -> dz=1, quotient 0, remainder 0, out_valid 1 edge after accept.
REQ-036 SHALL test signed a=-7, b=2 -> quotient = -(3.5*2^64) two's complement (integer 0xFFFF_FFFC, fraction 0x8000_0000_0000_0000), remainder 0; signed a=0x8000_0000, b=0xFFFF_FFFF -> ovf=1.
REQ-037 SHALL test out_ready low 10 cycles in DONE -> outputs stable, in_ready 0, in_valid ignored; release -> IDLE next edge.
REQ-038 SHALL test rst_n pulsed at CALC iteration 40 -> all outputs 0, in_ready 1 after release, next request computes correctly.
